// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the mips memory responder.
package mips_mem_pkg;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_FETCH = 2'b01;
    localparam logic [1:0] FC_STORE = 2'b10;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/mips_dmem.sv
// Word RAM: synchronous write, asynchronous read; used for both imem and dmem.
module mips_dmem
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WORD_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WORD_W-1:0]        rdata
);
    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];
endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for the single-cycle mips core: boot loader, imem/dmem, access guard.
// Optional MIPS_DMEM_CLEAR_EN zeroes dmem one word per cycle after every reset.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        cpu_reset,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] fault_addr,
    output logic [15:0] store_count
);
    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);

    state_e             r_state;
    logic [IW-1:0]      r_ptr;
    logic               r_cpu_reset;
    logic               r_fault;
    logic [1:0]         r_fault_code;
    logic [31:0]        r_fault_addr;
    logic [CNT_W-1:0]   r_store_count;

    logic [IW-1:0]      w_fetch_idx;
    logic [DW-1:0]      w_data_idx;
    logic               w_fetch_bad;
    logic               w_data_oor;
    logic               w_store_bad;
    logic               w_store_ok;
    logic               w_imem_we;
    logic [WORD_W-1:0]  w_imem_rdata;
    logic               w_dmem_we;
    logic [DW-1:0]      w_dmem_waddr;
    logic [WORD_W-1:0]  w_dmem_wdata;
    logic [WORD_W-1:0]  w_dmem_rdata;

    assign w_fetch_idx = pc[IW+1:2];
    assign w_data_idx  = aluout[DW+1:2];
    assign w_fetch_bad = (pc[1:0] != 2'b00) || ((pc >> (IW + 2)) != 32'd0);
    assign w_data_oor  = (aluout >> (DW + 2)) != 32'd0;
    assign w_store_bad = memwrite && ((aluout[1:0] != 2'b00) || w_data_oor);
    // A fetch fault turns the cycle into a nop, so its store is dropped as well.
    assign w_store_ok  = (r_state == ST_RUN) && !reset && memwrite && !w_store_bad && !w_fetch_bad;
    assign w_imem_we   = (r_state == ST_LOAD) && load_valid && !reset;

`ifdef MIPS_DMEM_CLEAR_EN
    logic [DW-1:0] r_clr_ptr;
    logic          w_clearing;

    assign w_clearing   = (r_state == ST_CLEAR) && !reset;
    assign w_dmem_we    = w_clearing || w_store_ok;
    assign w_dmem_waddr = w_clearing ? r_clr_ptr : w_data_idx;
    assign w_dmem_wdata = w_clearing ? '0 : writedata;
`else
    assign w_dmem_we    = w_store_ok;
    assign w_dmem_waddr = w_data_idx;
    assign w_dmem_wdata = writedata;
`endif

    mips_dmem #(.DEPTH(IMEM_WORDS)) u_imem (
        .clk   (clk),
        .we    (w_imem_we),
        .waddr (r_ptr),
        .wdata (load_data),
        .raddr (w_fetch_idx),
        .rdata (w_imem_rdata)
    );

    mips_dmem #(.DEPTH(DMEM_WORDS)) u_dmem (
        .clk   (clk),
        .we    (w_dmem_we),
        .waddr (w_dmem_waddr),
        .wdata (w_dmem_wdata),
        .raddr (w_data_idx),
        .rdata (w_dmem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef MIPS_DMEM_CLEAR_EN
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
`else
            r_state   <= ST_LOAD;
`endif
            r_ptr         <= '0;
            r_cpu_reset   <= 1'b1;
            r_fault       <= 1'b0;
            r_fault_code  <= FC_NONE;
            r_fault_addr  <= '0;
            r_store_count <= '0;
        end else begin
            case (r_state)
`ifdef MIPS_DMEM_CLEAR_EN
                ST_CLEAR: begin
                    r_cpu_reset <= 1'b1;
                    r_clr_ptr   <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == DW'(DMEM_WORDS - 1)) begin
                        r_state <= ST_LOAD;
                    end
                end
`endif
                ST_LOAD: begin
                    if (load_valid) begin
                        r_ptr <= r_ptr + 1'b1;
                        // cpu_reset drops together with the move to RUN.
                        if (load_last || (r_ptr == IW'(IMEM_WORDS - 1))) begin
                            r_state     <= ST_RUN;
                            r_cpu_reset <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_fetch_bad) begin
                        r_state      <= ST_FAULT;
                        r_cpu_reset  <= 1'b1;
                        r_fault      <= 1'b1;
                        r_fault_code <= FC_FETCH;
                        r_fault_addr <= pc;
                    end else if (w_store_bad) begin
                        r_state      <= ST_FAULT;
                        r_cpu_reset  <= 1'b1;
                        r_fault      <= 1'b1;
                        r_fault_code <= FC_STORE;
                        r_fault_addr <= aluout;
                    end else if (w_store_ok) begin
                        r_store_count <= sat_inc(r_store_count);
                    end
                end
                ST_FAULT: begin
                    r_cpu_reset <= 1'b1;
                end
                default: begin
                    r_state     <= ST_LOAD;
                    r_cpu_reset <= 1'b1;
                end
            endcase
        end
    end

    assign load_ready  = (r_state == ST_LOAD);
    assign cpu_reset   = r_cpu_reset;
    assign instr       = ((r_state == ST_RUN) && !w_fetch_bad) ? w_imem_rdata : '0;
    assign readdata    = w_data_oor ? '0 : w_dmem_rdata;
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;
    assign fault_addr  = r_fault_addr;
    assign store_count = r_store_count;
endmodule
